// File: rtl/decode_exec_reg.sv
// rtl/decode_exec_reg.sv - decode-to-execute pipeline register with load-use bubble, flush and backpressure
// Optional DECODE_EXEC_STATS_EN adds bubbleCnt/stallCnt event counters.
module decode_exec_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               idValid,
    output logic               idReady,
    input  logic [XLEN-1:0]    idPc,
    input  logic [4:0]         idRa1,
    input  logic [4:0]         idRa2,
    input  logic               idUsesRs1,
    input  logic               idUsesRs2,
    input  logic [XLEN-1:0]    idR1Val,
    input  logic [XLEN-1:0]    idR2Val,
    input  logic [XLEN-1:0]    idImm,
    input  logic [4:0]         idRd,
    input  logic               idRegWrite,
    input  logic               idMemRead,
    input  logic               idMemWrite,
    input  logic [ALUOP_W-1:0] idAluOp,
    input  logic [2:0]         idFunct3,
    input  logic               exReady,
    input  logic               execMemValid,
    input  logic               flush,
    output logic               exValid,
    output logic [XLEN-1:0]    exPc,
    output logic [XLEN-1:0]    exR1Val,
    output logic [XLEN-1:0]    exR2Val,
    output logic [XLEN-1:0]    exImm,
    output logic [4:0]         exRa1,
    output logic [4:0]         exRa2,
    output logic [4:0]         exRd,
    output logic               exRegWrite,
    output logic               exMemRead,
    output logic               exMemWrite,
    output logic [ALUOP_W-1:0] exAluOp,
    output logic [2:0]         exFunct3
`ifdef DECODE_EXEC_STATS_EN
    ,
    output logic [31:0]        bubbleCnt,
    output logic [31:0]        stallCnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    r1;
        logic [XLEN-1:0]    r2;
        logic [XLEN-1:0]    imm;
        logic [4:0]         ra1;
        logic [4:0]         ra2;
        logic [4:0]         rd;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic [ALUOP_W-1:0] alu_op;
        logic [2:0]         funct3;
    } ex_fields_t;

    ex_fields_t fields_q, fields_d;
    logic       valid_q, valid_d;
    logic       advance;
    logic       load_use;
    logic       rs1_hit, rs2_hit;

    assign advance  = !valid_q || exReady;
    assign rs1_hit  = idUsesRs1 && (idRa1 == fields_q.rd);
    assign rs2_hit  = idUsesRs2 && (idRa2 == fields_q.rd);
    // Load data not yet back: a dependent consumer must wait one slot.
    assign load_use = valid_q && fields_q.mem_read && !execMemValid &&
                      (fields_q.rd != 5'd0) && (rs1_hit || rs2_hit);
    assign idReady  = advance && !load_use && !flush;

    always_comb begin
        fields_d = fields_q;
        valid_d  = valid_q;
        if (flush) begin
            valid_d            = 1'b0;
            fields_d.reg_write = 1'b0;
            fields_d.mem_read  = 1'b0;
            fields_d.mem_write = 1'b0;
        end else if (advance) begin
            if (!load_use && idValid) begin
                valid_d            = 1'b1;
                fields_d.pc        = idPc;
                fields_d.r1        = idR1Val;
                fields_d.r2        = idR2Val;
                fields_d.imm       = idImm;
                fields_d.ra1       = idRa1;
                fields_d.ra2       = idRa2;
                fields_d.rd        = idRd;
                fields_d.reg_write = idRegWrite;
                fields_d.mem_read  = idMemRead;
                fields_d.mem_write = idMemWrite;
                fields_d.alu_op    = idAluOp;
                fields_d.funct3    = idFunct3;
            end else begin
                // Bubble or empty slot: data is kept, only validity and side effects drop.
                valid_d            = 1'b0;
                fields_d.reg_write = 1'b0;
                fields_d.mem_read  = 1'b0;
                fields_d.mem_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            fields_q <= fields_d;
            valid_q  <= valid_d;
        end
    end

    assign exValid    = valid_q;
    assign exPc       = fields_q.pc;
    assign exR1Val    = fields_q.r1;
    assign exR2Val    = fields_q.r2;
    assign exImm      = fields_q.imm;
    assign exRa1      = fields_q.ra1;
    assign exRa2      = fields_q.ra2;
    assign exRd       = fields_q.rd;
    assign exRegWrite = fields_q.reg_write && valid_q;
    assign exMemRead  = fields_q.mem_read && valid_q;
    assign exMemWrite = fields_q.mem_write && valid_q;
    assign exAluOp    = fields_q.alu_op;
    assign exFunct3   = fields_q.funct3;

`ifdef DECODE_EXEC_STATS_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (!flush && advance && load_use) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (!flush && idValid && !idReady) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubbleCnt = bubble_cnt_q;
    assign stallCnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_exec_reg.sv
// tb/tb_decode_exec_reg.sv - scoreboard bench for decode_exec_reg
module tb_decode_exec_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [3:0]  alu;
        logic [2:0]  f3;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idValid, idUsesRs1, idUsesRs2, exReady, execMemValid, flush;
    instr_t      drv;
    logic        idReady, exValid;
    logic [31:0] exPc, exR1Val, exR2Val, exImm;
    logic [4:0]  exRa1, exRa2, exRd;
    logic        exRegWrite, exMemRead, exMemWrite;
    logic [3:0]  exAluOp;
    logic [2:0]  exFunct3;
    instr_t      ex_obs;
`ifdef DECODE_EXEC_STATS_EN
    logic [31:0] bubbleCnt, stallCnt;
`endif

    always #5 clk = ~clk;

    decode_exec_reg #(.XLEN(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .idValid(idValid), .idReady(idReady),
        .idPc(drv.pc), .idRa1(drv.ra1), .idRa2(drv.ra2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .idR1Val(drv.r1), .idR2Val(drv.r2), .idImm(drv.imm), .idRd(drv.rd),
        .idRegWrite(drv.rw), .idMemRead(drv.mr), .idMemWrite(drv.mw),
        .idAluOp(drv.alu), .idFunct3(drv.f3),
        .exReady(exReady), .execMemValid(execMemValid), .flush(flush),
        .exValid(exValid), .exPc(exPc), .exR1Val(exR1Val), .exR2Val(exR2Val), .exImm(exImm),
        .exRa1(exRa1), .exRa2(exRa2), .exRd(exRd),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exAluOp(exAluOp), .exFunct3(exFunct3)
`ifdef DECODE_EXEC_STATS_EN
        , .bubbleCnt(bubbleCnt), .stallCnt(stallCnt)
`endif
    );

    assign ex_obs = {exPc, exR1Val, exR2Val, exImm, exRa1, exRa2, exRd,
                     exRegWrite, exMemRead, exMemWrite, exAluOp, exFunct3};

    int     total = 0;
    int     bad = 0;
    int     exp_bubbles = 0;
    int     exp_stalls = 0;
    instr_t m_cur;
    logic   m_valid;
    instr_t sb_q[$];

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2,
                                  input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        instr_t t;
        t.pc  = pc;
        t.r1  = $urandom;
        t.r2  = $urandom;
        t.imm = $urandom;
        t.ra1 = ra1;
        t.ra2 = ra2;
        t.rd  = rd;
        t.rw  = rw;
        t.mr  = mr;
        t.mw  = mw;
        t.alu = 4'($urandom_range(0, 15));
        t.f3  = 3'($urandom_range(0, 7));
        return t;
    endfunction

    function automatic void model_clear_ctrl();
        m_valid  = 1'b0;
        m_cur.rw = 1'b0;
        m_cur.mr = 1'b0;
        m_cur.mw = 1'b0;
    endfunction

    // Starts at posedge+1, ends at the next posedge+1.
    task automatic cycle(input instr_t in, input logic v, input logic u1, input logic u2,
                         input logic exr, input logic emv, input logic fl);
        logic   adv, lu, rdy, captured;
        instr_t popped;
        drv = in; idValid = v; idUsesRs1 = u1; idUsesRs2 = u2;
        exReady = exr; execMemValid = emv; flush = fl;
        #1;
        adv = !m_valid || exr;
        lu  = m_valid && m_cur.mr && !emv && (m_cur.rd != 5'd0) &&
              ((u1 && in.ra1 == m_cur.rd) || (u2 && in.ra2 == m_cur.rd));
        rdy = adv && !lu && !fl;
        check("idReady", {199'd0, idReady}, {199'd0, rdy});
        captured = 1'b0;
        if (v && !rdy && !fl) exp_stalls++;
        if (fl) begin
            model_clear_ctrl();
        end else if (adv) begin
            if (lu) begin
                model_clear_ctrl();
                exp_bubbles++;
            end else if (v) begin
                m_cur = in;
                m_valid = 1'b1;
                sb_q.push_back(in);
                captured = 1'b1;
            end else begin
                model_clear_ctrl();
            end
        end
        @(posedge clk);
        #1;
        check("exValid", {199'd0, exValid}, {199'd0, m_valid});
        check("exFields", {47'd0, ex_obs}, {47'd0, m_cur});
        if (captured && exValid && sb_q.size() > 0) begin
            popped = sb_q.pop_front();
            check("sbPop", {47'd0, ex_obs}, {47'd0, popped});
        end
    endtask

    task automatic check_reset_state();
        check("rstValid", {199'd0, exValid}, 200'd0);
        check("rstFields", {47'd0, ex_obs}, 200'd0);
        check("rstIdReady", {199'd0, idReady}, 200'd1);
`ifdef DECODE_EXEC_STATS_EN
        check("rstBubbleCnt", {168'd0, bubbleCnt}, 200'd0);
        check("rstStallCnt", {168'd0, stallCnt}, 200'd0);
`endif
        m_valid = 1'b0;
        m_cur = '0;
        sb_q.delete();
        exp_bubbles = 0;
        exp_stalls = 0;
    endtask

    instr_t t_b, t_f, t_g;

    initial begin
        rst_n = 1'b0;
        drv = '0; idValid = 0; idUsesRs1 = 0; idUsesRs2 = 0;
        exReady = 1; execMemValid = 0; flush = 0;
        #2;
        check_reset_state();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic capture
        cycle(mk(32'h100, 5'd1, 5'd2, 5'd5, 1, 0, 0), 1, 1, 1, 1, 0, 0);
        check("exPc", {168'd0, exPc}, 200'h100);
        check("exRd", {195'd0, exRd}, 200'd5);
        check("exRegWrite", {199'd0, exRegWrite}, 200'd1);

        // Load-use on rs1 -> bubble then capture
        cycle(mk(32'h104, 5'd0, 5'd0, 5'd7, 1, 1, 0), 1, 0, 0, 1, 0, 0);
        t_b = mk(32'h108, 5'd7, 5'd3, 5'd8, 1, 0, 1);
        cycle(t_b, 1, 1, 0, 1, 0, 0);
        check("bubbleCtrl", {197'd0, exRegWrite, exMemRead, exMemWrite}, 200'd0);
        cycle(t_b, 1, 1, 0, 1, 0, 0);

        // Non-hazards: unused source, rd=0, load data already present
        cycle(mk(32'h10c, 5'd0, 5'd0, 5'd7, 1, 1, 0), 1, 0, 0, 1, 0, 0);
        cycle(mk(32'h110, 5'd7, 5'd7, 5'd9, 1, 0, 0), 1, 0, 0, 1, 0, 0);
        cycle(mk(32'h114, 5'd0, 5'd0, 5'd0, 0, 1, 0), 1, 0, 0, 1, 0, 0);
        cycle(mk(32'h118, 5'd0, 5'd0, 5'd4, 1, 0, 0), 1, 1, 1, 1, 0, 0);
        cycle(mk(32'h11c, 5'd0, 5'd0, 5'd7, 1, 1, 0), 1, 0, 0, 1, 0, 0);
        cycle(mk(32'h120, 5'd1, 5'd7, 5'd4, 1, 0, 0), 1, 0, 1, 1, 1, 0);

        // Second load-use, on rs2
        cycle(mk(32'h124, 5'd0, 5'd0, 5'd9, 1, 1, 0), 1, 0, 0, 1, 0, 0);
        t_f = mk(32'h128, 5'd2, 5'd9, 5'd10, 1, 0, 0);
        cycle(t_f, 1, 0, 1, 1, 0, 0);
        cycle(t_f, 1, 0, 1, 1, 0, 0);

        // Backpressure for 3 cycles, then release
        t_g = mk(32'h12c, 5'd1, 5'd1, 5'd11, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(t_g, 1, 1, 1, 0, 0, 0);
        check("holdPc", {168'd0, exPc}, 200'h128);
`ifdef DECODE_EXEC_STATS_EN
        check("bubbleCnt2", {168'd0, bubbleCnt}, 200'd2);
        check("stallCnt5", {168'd0, stallCnt}, 200'd5);
`endif
        cycle(t_g, 1, 1, 1, 1, 0, 0);

        // Flush beats backpressure
        cycle(mk(32'h130, 5'd1, 5'd1, 5'd12, 1, 1, 1), 1, 1, 1, 0, 0, 1);
        check("flushCtrl", {196'd0, exValid, exRegWrite, exMemRead, exMemWrite}, 200'd0);

        // Randomised traffic over a small register space to provoke hazards
        for (int i = 0; i < 300; i++) begin
            cycle(mk($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end
`ifdef DECODE_EXEC_STATS_EN
        check("bubbleCntRnd", {168'd0, bubbleCnt}, 200'(exp_bubbles));
        check("stallCntRnd", {168'd0, stallCnt}, 200'(exp_stalls));
`endif
        check("sbEmpty", 200'(sb_q.size()), 200'd0);

        // Reset asserted in the middle of a load-use stall
        cycle(mk(32'h200, 5'd0, 5'd0, 5'd6, 1, 1, 0), 1, 0, 0, 1, 0, 0);
        drv = mk(32'h204, 5'd6, 5'd0, 5'd3, 1, 0, 0);
        idValid = 1; idUsesRs1 = 1; idUsesRs2 = 0; exReady = 1; execMemValid = 0; flush = 0;
        #1;
        check("stallIdReady", {199'd0, idReady}, 200'd0);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk); #1;
        check("rstHoldValid", {199'd0, exValid}, 200'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(mk(32'h300, 5'd6, 5'd0, 5'd3, 1, 0, 0), 1, 1, 0, 1, 0, 0);
        check("postRstPc", {168'd0, exPc}, 200'h300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
